// File: rtl/axi_mst_pkg.sv
// Shared types and constants for the multi-channel AXI-lite master arbiter.
package axi_mst_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned MAX_NUM_CH = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    DONE_WAIT = 2'd2,
    BACKOFF   = 2'd3
  } mst_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward starting one past ptr_i.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr_i) + k) % N);
      if (!gnt_vld_o && req_i[cand]) begin
        gnt_vld_o       = 1'b1;
        gnt_idx_o       = cand;
        gnt_oh_o[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_mst_arb.sv
// Arbitrates NUM_CH pulse-driven register requesters onto one AXI-lite master
// (IPIF) command port, with rearbitrate retry and a transaction watchdog.
module axi_lite_mst_arb
  import axi_mst_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WDT_W  = 28
) (
  input  logic                           axi_clk,
  input  logic                           rst_n,
  input  logic [NUM_CH*ADDR_W-1:0]       ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]       ch_wr_data,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   ch_be,
  input  logic [NUM_CH-1:0]              ch_rd_go,
  input  logic [NUM_CH-1:0]              ch_wr_go,
  output logic [DATA_W-1:0]              ch_rd_data,
  output logic [NUM_CH-1:0]              ch_rd_done,
  output logic [NUM_CH-1:0]              ch_wr_done,
  output logic [NUM_CH-1:0]              ch_error,
  output logic [NUM_CH-1:0]              ch_timeout,
  output logic                           IP2Bus_MstRd_Req,
  output logic                           IP2Bus_MstWr_Req,
  output logic [ADDR_W-1:0]              IP2Bus_Mst_Addr,
  output logic [DATA_W/8-1:0]            IP2Bus_Mst_BE,
  output logic [DATA_W-1:0]              IP2Bus_MstWr_d,
  output logic                           IP2Bus_Mst_Lock,
  output logic                           IP2Bus_Mst_Reset,
  input  logic                           Bus2IP_Mst_CmdAck,
  input  logic                           Bus2IP_Mst_Cmplt,
  input  logic                           Bus2IP_Mst_Error,
  input  logic                           Bus2IP_Mst_Rearbitrate,
  input  logic                           Bus2IP_Mst_Timeout,
  input  logic [DATA_W-1:0]              Bus2IP_MstRd_d,
  input  logic                           Bus2IP_MstRd_src_rdy_n,
  input  logic                           Bus2IP_MstWr_dst_rdy_n
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  mst_state_e         state_q, state_d;
  logic [NUM_CH-1:0]  pend_q, pend_d;
  logic [NUM_CH-1:0]  pend_wr_q, pend_wr_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               dir_wr_q, dir_wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [WDT_W-1:0]   wdt_q, wdt_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [NUM_CH-1:0]  rd_done_q, rd_done_d;
  logic [NUM_CH-1:0]  wr_done_q, wr_done_d;
  logic [NUM_CH-1:0]  err_q, err_d;
  logic [NUM_CH-1:0]  tmo_q, tmo_d;
  logic               rd_req_q, rd_req_d;
  logic               wr_req_q, wr_req_d;

  logic [ADDR_W-1:0]  addr_arr  [NUM_CH];
  logic [DATA_W-1:0]  wdata_arr [NUM_CH];
  logic [BE_W-1:0]    be_arr    [NUM_CH];

  logic [NUM_CH-1:0]  arb_oh_unused;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  logic               wdt_expire_c;
  logic               bus_err_c;
  logic               unused_c;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign addr_arr[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = ch_wr_data[gi*DATA_W +: DATA_W];
    assign be_arr[gi]    = ch_be[gi*BE_W +: BE_W];
  end

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (IDX_W)
  ) u_rr_arbiter (
    .req_i     (pend_q),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (arb_oh_unused),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  assign wdt_expire_c = (state_q != IDLE) && (wdt_q == {WDT_W{1'b1}});
  assign bus_err_c    = Bus2IP_Mst_Error | Bus2IP_Mst_Timeout;
  assign unused_c     = Bus2IP_MstWr_dst_rdy_n ^ (^arb_oh_unused);

  // Next-state, request queuing and completion pulses
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    dir_wr_d  = dir_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rd_data_d = rd_data_q;
    wdt_d     = '0;
    rd_done_d = '0;
    wr_done_d = '0;
    err_d     = '0;
    tmo_d     = '0;

    if (state_q == IDLE) begin
      if (arb_vld) begin
        ptr_d           = arb_idx;
        gnt_d           = arb_idx;
        dir_wr_d        = pend_wr_q[arb_idx];
        addr_d          = addr_arr[arb_idx];
        wdata_d         = wdata_arr[arb_idx];
        be_d            = be_arr[arb_idx];
        pend_d[arb_idx] = 1'b0;
        state_d         = REQ;
      end
    end else begin
      wdt_d = wdt_q + WDT_W'(1);
      if (bus_err_c) begin
        err_d[gnt_q] = 1'b1;
        state_d      = IDLE;
        wdt_d        = '0;
      end else if (wdt_expire_c) begin
        err_d[gnt_q] = 1'b1;
        tmo_d[gnt_q] = 1'b1;
        state_d      = IDLE;
        wdt_d        = '0;
      end else begin
        case (state_q)
          REQ: begin
            if (Bus2IP_Mst_CmdAck) begin
              state_d = DONE_WAIT;
            end else if (Bus2IP_Mst_Rearbitrate) begin
              state_d = BACKOFF;
            end
          end
          BACKOFF: state_d = REQ;
          DONE_WAIT: begin
            if (Bus2IP_Mst_Cmplt) begin
              if (dir_wr_q) begin
                wr_done_d[gnt_q] = 1'b1;
                state_d          = IDLE;
              end else if (!Bus2IP_MstRd_src_rdy_n) begin
                rd_done_d[gnt_q] = 1'b1;
                rd_data_d        = Bus2IP_MstRd_d;
                state_d          = IDLE;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // A go is dropped while the channel is already queued or in flight
    for (int i = 0; i < NUM_CH; i++) begin
      if ((ch_rd_go[i] | ch_wr_go[i]) && !pend_q[i] &&
          !((state_q != IDLE) && (gnt_q == IDX_W'(i)))) begin
        pend_d[i]    = 1'b1;
        pend_wr_d[i] = ch_wr_go[i] & ~ch_rd_go[i];
      end
    end

    rd_req_d = (state_d == REQ) && !dir_wr_d;
    wr_req_d = (state_d == REQ) && dir_wr_d;
  end

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      pend_wr_q <= '0;
      ptr_q     <= IDX_W'(NUM_CH - 1);
      gnt_q     <= '0;
      dir_wr_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      wdt_q     <= '0;
      rd_data_q <= '0;
      rd_done_q <= '0;
      wr_done_q <= '0;
      err_q     <= '0;
      tmo_q     <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      dir_wr_q  <= dir_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      wdt_q     <= wdt_d;
      rd_data_q <= rd_data_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
    end
  end

  assign ch_rd_data       = rd_data_q;
  assign ch_rd_done       = rd_done_q;
  assign ch_wr_done       = wr_done_q;
  assign ch_error         = err_q;
  assign ch_timeout       = tmo_q;
  assign IP2Bus_MstRd_Req = rd_req_q;
  assign IP2Bus_MstWr_Req = wr_req_q;
  assign IP2Bus_Mst_Addr  = addr_q;
  assign IP2Bus_Mst_BE    = be_q;
  assign IP2Bus_MstWr_d   = wdata_q;
  assign IP2Bus_Mst_Lock  = 1'b0;
  assign IP2Bus_Mst_Reset = ~rst_n | Bus2IP_Mst_Error | wdt_expire_c;

endmodule

// File: tb/tb_axi_lite_mst_arb.sv
// Bench for axi_lite_mst_arb: directed steps with randomized payloads and timing,
// checked against a pending-set / round-robin reference model.
module tb_axi_lite_mst_arb;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned WW  = 6;
  localparam int          WDT_MAX = (1 << WW) - 1;

  logic                axi_clk = 1'b0;
  logic                rst_n;
  logic [NCH*AW-1:0]   ch_addr;
  logic [NCH*DW-1:0]   ch_wr_data;
  logic [NCH*BW-1:0]   ch_be;
  logic [NCH-1:0]      ch_rd_go, ch_wr_go;
  logic [DW-1:0]       ch_rd_data;
  logic [NCH-1:0]      ch_rd_done, ch_wr_done, ch_error, ch_timeout;
  logic                IP2Bus_MstRd_Req, IP2Bus_MstWr_Req;
  logic [AW-1:0]       IP2Bus_Mst_Addr;
  logic [BW-1:0]       IP2Bus_Mst_BE;
  logic [DW-1:0]       IP2Bus_MstWr_d;
  logic                IP2Bus_Mst_Lock, IP2Bus_Mst_Reset;
  logic                Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error;
  logic                Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Timeout;
  logic [DW-1:0]       Bus2IP_MstRd_d;
  logic                Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n;

  logic [AW-1:0] ta [NCH];
  logic [DW-1:0] td [NCH];
  logic [BW-1:0] tb [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_pack
    assign ch_addr[gi*AW +: AW]    = ta[gi];
    assign ch_wr_data[gi*DW +: DW] = td[gi];
    assign ch_be[gi*BW +: BW]      = tb[gi];
  end

  always #5 axi_clk = ~axi_clk;

  axi_lite_mst_arb #(
    .NUM_CH (NCH), .ADDR_W (AW), .DATA_W (DW), .WDT_W (WW)
  ) dut (
    .axi_clk                (axi_clk),
    .rst_n                  (rst_n),
    .ch_addr                (ch_addr),
    .ch_wr_data             (ch_wr_data),
    .ch_be                  (ch_be),
    .ch_rd_go               (ch_rd_go),
    .ch_wr_go               (ch_wr_go),
    .ch_rd_data             (ch_rd_data),
    .ch_rd_done             (ch_rd_done),
    .ch_wr_done             (ch_wr_done),
    .ch_error               (ch_error),
    .ch_timeout             (ch_timeout),
    .IP2Bus_MstRd_Req       (IP2Bus_MstRd_Req),
    .IP2Bus_MstWr_Req       (IP2Bus_MstWr_Req),
    .IP2Bus_Mst_Addr        (IP2Bus_Mst_Addr),
    .IP2Bus_Mst_BE          (IP2Bus_Mst_BE),
    .IP2Bus_MstWr_d         (IP2Bus_MstWr_d),
    .IP2Bus_Mst_Lock        (IP2Bus_Mst_Lock),
    .IP2Bus_Mst_Reset       (IP2Bus_Mst_Reset),
    .Bus2IP_Mst_CmdAck      (Bus2IP_Mst_CmdAck),
    .Bus2IP_Mst_Cmplt       (Bus2IP_Mst_Cmplt),
    .Bus2IP_Mst_Error       (Bus2IP_Mst_Error),
    .Bus2IP_Mst_Rearbitrate (Bus2IP_Mst_Rearbitrate),
    .Bus2IP_Mst_Timeout     (Bus2IP_Mst_Timeout),
    .Bus2IP_MstRd_d         (Bus2IP_MstRd_d),
    .Bus2IP_MstRd_src_rdy_n (Bus2IP_MstRd_src_rdy_n),
    .Bus2IP_MstWr_dst_rdy_n (Bus2IP_MstWr_dst_rdy_n)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: set of queued channels, their captured payloads, last grant
  bit [NCH-1:0]  m_pend;
  bit            m_pwr  [NCH];
  logic [AW-1:0] m_addr [NCH];
  logic [DW-1:0] m_data [NCH];
  logic [BW-1:0] m_be   [NCH];
  int            m_last;
  int            m_inflight;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  function automatic logic [NCH-1:0] onehot(input int i);
    return NCH'(1) << i;
  endfunction

  function automatic void m_reset();
    m_pend     = '0;
    m_last     = NCH - 1;
    m_inflight = -1;
  endfunction

  function automatic void m_go(input logic [NCH-1:0] rd, input logic [NCH-1:0] wr);
    for (int i = 0; i < NCH; i++) begin
      if ((rd[i] | wr[i]) && !m_pend[i] && m_inflight != i) begin
        m_pend[i] = 1'b1;
        m_pwr[i]  = wr[i] & ~rd[i];
        m_addr[i] = ta[i];
        m_data[i] = td[i];
        m_be[i]   = tb[i];
      end
    end
  endfunction

  function automatic int m_next();
    int c;
    for (int k = 1; k <= NCH; k++) begin
      c = (m_last + k) % NCH;
      if (m_pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic rnd_ch(input int i);
    ta[i] = $urandom & 32'hFFFF_FFFC;
    td[i] = $urandom;
    tb[i] = BW'($urandom_range(1, 15));
  endtask

  task automatic go(input logic [NCH-1:0] rd, input logic [NCH-1:0] wr);
    ch_rd_go = rd;
    ch_wr_go = wr;
    m_go(rd, wr);
    tick();
    ch_rd_go = '0;
    ch_wr_go = '0;
  endtask

  task automatic wait_grant(output int g, output bit wr, output int lat);
    lat = 0;
    while (!(IP2Bus_MstRd_Req | IP2Bus_MstWr_Req) && lat < 40) begin
      tick();
      lat++;
    end
    g = m_next();
    chk("req_seen", 64'(IP2Bus_MstRd_Req | IP2Bus_MstWr_Req), 64'(1));
    chk("model_has_pending", 64'(g >= 0), 64'(1));
    if (g < 0) g = 0;
    wr = m_pwr[g];
    m_pend[g]  = 1'b0;
    m_last     = g;
    m_inflight = g;
    chk("req_dir", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), wr ? 64'(2'b01) : 64'(2'b10));
    chk("mst_addr", 64'(IP2Bus_Mst_Addr), 64'(m_addr[g]));
    chk("mst_wrd", 64'(IP2Bus_MstWr_d), 64'(m_data[g]));
    chk("mst_be", 64'(IP2Bus_Mst_BE), 64'(m_be[g]));
  endtask

  task automatic xact(input int n_rearb, input int ack_dly, input int cmp_dly,
                      input logic [DW-1:0] rdv, input bit regow, output int lat);
    int g;
    bit wr;
    logic [1:0] rq;
    wait_grant(g, wr, lat);
    rq = wr ? 2'b01 : 2'b10;
    for (int r = 0; r < n_rearb; r++) begin
      Bus2IP_Mst_Rearbitrate = 1'b1;
      tick();
      Bus2IP_Mst_Rearbitrate = 1'b0;
      chk("rearb_req_low", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), 64'(0));
      tick();
      chk("rearb_req_again", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), 64'(rq));
      chk("rearb_addr", 64'(IP2Bus_Mst_Addr), 64'(m_addr[g]));
      chk("rearb_wrd", 64'(IP2Bus_MstWr_d), 64'(m_data[g]));
    end
    repeat (ack_dly) begin
      tick();
      chk("req_hold", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), 64'(rq));
    end
    Bus2IP_Mst_CmdAck = 1'b1;
    tick();
    Bus2IP_Mst_CmdAck = 1'b0;
    chk("req_drop", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), 64'(0));
    repeat (cmp_dly - 1) tick();
    Bus2IP_Mst_Cmplt = 1'b1;
    if (!wr) begin
      Bus2IP_MstRd_src_rdy_n = 1'b0;
      Bus2IP_MstRd_d         = rdv;
    end
    tick();
    Bus2IP_Mst_Cmplt       = 1'b0;
    Bus2IP_MstRd_src_rdy_n = 1'b1;
    chk("rd_done", 64'(ch_rd_done), wr ? 64'(0) : 64'(onehot(g)));
    chk("wr_done", 64'(ch_wr_done), wr ? 64'(onehot(g)) : 64'(0));
    chk("no_err_on_done", 64'(ch_error), 64'(0));
    chk("no_req_at_done", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), 64'(0));
    if (!wr) chk("rd_data", 64'(ch_rd_data), 64'(rdv));
    m_inflight = -1;
    if (regow) begin
      rnd_ch(g);
      ch_wr_go = onehot(g);
      m_go('0, onehot(g));
    end
    tick();
    ch_wr_go = '0;
    chk("done_single", 64'(ch_rd_done | ch_wr_done), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not reach its end");
    $fatal(1, "bench timeout");
  end

  initial begin
    int g, lat, guard;
    bit wr;
    logic [NCH-1:0] rv, wv;

    rst_n = 1'b0;
    ch_rd_go = '0; ch_wr_go = '0;
    Bus2IP_Mst_CmdAck = 0; Bus2IP_Mst_Cmplt = 0; Bus2IP_Mst_Error = 0;
    Bus2IP_Mst_Rearbitrate = 0; Bus2IP_Mst_Timeout = 0;
    Bus2IP_MstRd_d = '0; Bus2IP_MstRd_src_rdy_n = 1'b1; Bus2IP_MstWr_dst_rdy_n = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      ta[i] = '0; td[i] = '0; tb[i] = '0;
    end
    m_reset();
    repeat (3) tick();
    chk("rst_mst_reset_active", 64'(IP2Bus_Mst_Reset), 64'(1));
    rst_n = 1'b1;
    tick();
    chk("rst_mst_reset", 64'(IP2Bus_Mst_Reset), 64'(0));
    chk("rst_reqs", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), 64'(0));
    chk("rst_addr", 64'(IP2Bus_Mst_Addr), 64'(0));
    chk("rst_wrd", 64'(IP2Bus_MstWr_d), 64'(0));
    chk("rst_be", 64'(IP2Bus_Mst_BE), 64'(0));
    chk("rst_rd_data", 64'(ch_rd_data), 64'(0));
    chk("rst_pulses", 64'({ch_rd_done, ch_wr_done, ch_error, ch_timeout}), 64'(0));
    chk("lock_tied", 64'(IP2Bus_Mst_Lock), 64'(0));

    // Single write on ch0: exact latency, ack after 3, cmplt 2 later
    ta[0] = 32'h0000_1000; td[0] = 32'hDEAD_BEEF; tb[0] = 4'hF;
    go(2'b00, 2'b01);
    chk("req_not_yet_cycle1", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), 64'(0));
    xact(0, 3, 2, '0, 1'b0, lat);
    chk("go_to_req_latency", 64'(lat), 64'(1));

    // Three rounds of simultaneous reads on both channels
    for (int n = 0; n < 3; n++) begin
      rnd_ch(0); rnd_ch(1);
      go(2'b11, 2'b00);
      xact(0, $urandom_range(0, 3), $urandom_range(1, 3), 32'hA5A5_0001 + DW'(2*n), 1'b0, lat);
      xact(0, $urandom_range(0, 3), $urandom_range(1, 3), 32'hA5A5_0002 + DW'(2*n), 1'b0, lat);
    end

    // Two rearbitrates then ack on ch1
    rnd_ch(1);
    go(2'b00, 2'b10);
    xact(2, 1, 2, '0, 1'b0, lat);

    // Repeated go while queued / in flight is dropped; simultaneous go reads
    rnd_ch(0);
    go(2'b00, 2'b01);
    go(2'b01, 2'b00);
    go(2'b01, 2'b00);
    xact(0, 1, 1, '0, 1'b0, lat);
    repeat (4) begin
      tick();
      chk("no_extra_req", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), 64'(0));
    end
    rnd_ch(0);
    go(2'b01, 2'b01);
    xact(0, 0, 1, $urandom, 1'b0, lat);

    // Go on the done cycle is accepted
    rnd_ch(1);
    go(2'b00, 2'b10);
    xact(0, 1, 1, '0, 1'b1, lat);
    xact(0, 1, 1, '0, 1'b0, lat);

    // Randomized traffic
    for (int it = 0; it < 10; it++) begin
      rv = NCH'($urandom_range(0, 3));
      wv = NCH'($urandom_range(0, 3));
      if ((rv | wv) == '0) wv = 2'b01;
      for (int i = 0; i < NCH; i++) if (rv[i] | wv[i]) rnd_ch(i);
      go(rv, wv);
      guard = 0;
      while (m_pend != '0 && guard < 8) begin
        xact($urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(1, 4), $urandom,
             ($urandom_range(0, 3) == 0), lat);
        guard++;
      end
    end

    // Watchdog: never acknowledge
    rnd_ch(0);
    go(2'b01, 2'b00);
    wait_grant(g, wr, lat);
    repeat (WDT_MAX - 1) tick();
    chk("wdt_reset_before", 64'(IP2Bus_Mst_Reset), 64'(0));
    chk("wdt_err_before", 64'(ch_error), 64'(0));
    tick();
    chk("wdt_mst_reset", 64'(IP2Bus_Mst_Reset), 64'(1));
    tick();
    chk("wdt_error", 64'(ch_error), 64'(onehot(g)));
    chk("wdt_timeout", 64'(ch_timeout), 64'(onehot(g)));
    chk("wdt_reset_one_cycle", 64'(IP2Bus_Mst_Reset), 64'(0));
    chk("wdt_req_low", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), 64'(0));
    chk("wdt_no_done", 64'(ch_rd_done | ch_wr_done), 64'(0));
    m_inflight = -1;
    tick();
    chk("wdt_pulse_single", 64'(ch_error | ch_timeout), 64'(0));

    // Bus error in DONE_WAIT, other channel follows
    rnd_ch(0); rnd_ch(1);
    go(2'b00, 2'b11);
    wait_grant(g, wr, lat);
    Bus2IP_Mst_CmdAck = 1'b1;
    tick();
    Bus2IP_Mst_CmdAck = 1'b0;
    tick();
    Bus2IP_Mst_Error = 1'b1;
    #1;
    chk("err_mst_reset", 64'(IP2Bus_Mst_Reset), 64'(1));
    tick();
    Bus2IP_Mst_Error = 1'b0;
    chk("err_pulse", 64'(ch_error), 64'(onehot(g)));
    chk("err_no_timeout", 64'(ch_timeout), 64'(0));
    chk("err_no_done", 64'(ch_rd_done | ch_wr_done), 64'(0));
    m_inflight = -1;
    xact(0, 1, 1, '0, 1'b0, lat);

    // Reset mid DONE_WAIT, late Cmplt ignored, pointer restarts at ch0
    rnd_ch(1);
    go(2'b10, 2'b00);
    wait_grant(g, wr, lat);
    Bus2IP_Mst_CmdAck = 1'b1;
    tick();
    Bus2IP_Mst_CmdAck = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_reqs", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), 64'(0));
    chk("mid_rst_addr", 64'(IP2Bus_Mst_Addr), 64'(0));
    chk("mid_rst_wrd_be", 64'({IP2Bus_MstWr_d, IP2Bus_Mst_BE}), 64'(0));
    chk("mid_rst_rd_data", 64'(ch_rd_data), 64'(0));
    chk("mid_rst_mst_reset", 64'(IP2Bus_Mst_Reset), 64'(1));
    tick();
    rst_n = 1'b1;
    tick();
    Bus2IP_Mst_Cmplt = 1'b1;
    Bus2IP_MstRd_src_rdy_n = 1'b0;
    Bus2IP_MstRd_d = 32'h1234_5678;
    tick();
    Bus2IP_Mst_Cmplt = 1'b0;
    Bus2IP_MstRd_src_rdy_n = 1'b1;
    chk("post_rst_no_done", 64'({ch_rd_done, ch_wr_done, ch_error}), 64'(0));
    chk("post_rst_rd_data", 64'(ch_rd_data), 64'(0));
    chk("post_rst_reqs", 64'({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}), 64'(0));
    rnd_ch(0); rnd_ch(1);
    go(2'b11, 2'b00);
    xact(0, 1, 1, $urandom, 1'b0, lat);
    xact(0, 1, 1, $urandom, 1'b0, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
